// File: rtl/read_ptr_empty.sv
// rtl/read_ptr_empty.sv - read-domain pointer, empty/almost-empty and fill-level stage of the async FIFO
//
// Ports:
//   clk         read-domain clock
//   rst         asynchronous active-low reset
//   read_enable consumer read request, ignored while rempty=1
//   wgry        write-domain Gray pointer (asynchronous to clk)
//   rempty      registered empty flag
//   raempty     registered almost-empty flag (level <= AE_THRESH)
//   rbin        memory read address
//   rgry        registered read Gray pointer, synchronised by the write domain
//   rlevel      registered fill level, 0..2^ADDR_W
module read_ptr_empty #(
  parameter int ADDR_W    = 4,
  parameter int AE_THRESH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              read_enable,
  input  logic [ADDR_W:0]   wgry,
  output logic              rempty,
  output logic              raempty,
  output logic [ADDR_W-1:0] rbin,
  output logic [ADDR_W:0]   rgry,
  output logic [ADDR_W:0]   rlevel
);

  localparam logic [ADDR_W:0] AE_T = AE_THRESH[ADDR_W:0];

  logic [ADDR_W:0] wq1;
  logic [ADDR_W:0] wq2;
  logic [ADDR_W:0] rptr_bin;
  logic [ADDR_W:0] rbinnext;
  logic [ADDR_W:0] rgraynext;
  logic [ADDR_W:0] wbin_s;
  logic [ADDR_W:0] lvl_next;
  logic            rd_go;

  // A read is only honoured when the FIFO is not (pessimistically) empty,
  // so the pointer can never overtake the synchronised write pointer.
  assign rd_go     = read_enable & ~rempty;
  assign rbinnext  = rptr_bin + {{ADDR_W{1'b0}}, rd_go};
  assign rgraynext = (rbinnext >> 1) ^ rbinnext;

  // Gray-to-binary of the synchronised write pointer: each bit is the XOR
  // of all Gray bits at or above it.
  always_comb begin
    wbin_s = '0;
    wbin_s[ADDR_W] = wq2[ADDR_W];
    for (int i = ADDR_W - 1; i >= 0; i--) begin
      wbin_s[i] = wbin_s[i+1] ^ wq2[i];
    end
  end

  // Modulo 2^(ADDR_W+1) subtraction keeps the level correct across laps.
  assign lvl_next = wbin_s - rbinnext;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wq1      <= '0;
      wq2      <= '0;
      rptr_bin <= '0;
      rgry     <= '0;
      rempty   <= 1'b1;
      raempty  <= 1'b1;
      rlevel   <= '0;
    end else begin
      wq1      <= wgry;
      wq2      <= wq1;
      rptr_bin <= rbinnext;
      rgry     <= rgraynext;
      // Compared against the pre-edge wq2, so the read of the last entry
      // raises rempty on that same edge.
      rempty   <= (rgraynext == wq2);
      raempty  <= (lvl_next <= AE_T);
      rlevel   <= lvl_next;
    end
  end

  assign rbin = rptr_bin[ADDR_W-1:0];

endmodule

// File: doc/read_ptr_empty.md
Name: read_ptr_empty

Overview:
- Read-domain pointer stage of the asynchronous FIFO; the read-side mirror of the write pointer/full-flag stage.
- Synchronises the write-domain Gray pointer into the read clock and maintains the binary/Gray read pointer.
- Generates registered empty and almost-empty flags plus a fill-level estimate for the read-side consumer.
- Its Gray pointer output is the one the write domain synchronises for its full comparison.

Parameters:
ADDR_W, 4, memory address width; pointers are ADDR_W+1 bits and FIFO depth is 2^ADDR_W.
AE_THRESH, 2, raempty asserts when the fill level is less than or equal to this value.

Ports:
clk  input  1  read-domain clock; all state updates on the rising edge.
rst  input  1  asynchronous, active-low reset; rst=0 clears all state immediately.
read_enable  input  1  consumer read request; honoured only when rempty=0.
wgry  input  ADDR_W+1  write-domain Gray pointer, asynchronous to clk.
rempty  output  1  registered FIFO-empty flag.
raempty  output  1  registered almost-empty flag.
rbin  output  ADDR_W  memory read address, equal to rptr_bin[ADDR_W-1:0].
rgry  output  ADDR_W+1  registered read Gray pointer.
rlevel  output  ADDR_W+1  registered fill level, range 0..2^ADDR_W.

Behaviour:
- Synchroniser: two flops, wq1<=wgry and wq2<=wq1; both reset to 0. No other logic reads wgry directly.
- Read pointer: internal rptr_bin is ADDR_W+1 bits.
  - rbinnext = rptr_bin + (read_enable & ~rempty).
  - rgraynext = (rbinnext>>1) ^ rbinnext.
  - Each edge: rptr_bin<=rbinnext and rgry<=rgraynext.
- Gray-to-binary of wq2: wbin_s[i] = XOR of wq2[ADDR_W:i], for i = ADDR_W down to 0.
- Empty: rempty <= (rgraynext == wq2).
- Level: lvl_next = wbin_s - rbinnext, modulo 2^(ADDR_W+1). rlevel<=lvl_next.
- Almost empty: raempty <= (lvl_next <= AE_THRESH).
- Reset values: rptr_bin=0, rgry=0, rbin=0, wq1=wq2=0, rempty=1, raempty=1, rlevel=0.
- Latency:
  - A wgry change, held stable, reaches wq2 on the 2nd clk edge.
  - rempty, raempty and rlevel reflect it on the 3rd edge.
  - A read updates rbin, rgry, rempty and rlevel on the same edge.
- Read while empty: ignored. Pointer, rgry and rlevel hold; no underflow.
- Empty is pessimistic: rempty may stay 1 for up to 3 cycles after data is written. It never deasserts while the FIFO is truly empty.
- Last-entry read: the read that makes rgraynext equal wq2 sets rempty=1 on that same edge, so there is no extra read.
- Wrap-around: rptr_bin wraps from 2^(ADDR_W+1)-1 to 0. The MSB distinguishes laps, rgry wraps from 10000 to 00000 (ADDR_W=4), and the level arithmetic stays correct modulo 2^(ADDR_W+1).
- Reset mid-operation: rst low clears all registers asynchronously, regardless of clk. Flags return to rempty=1, raempty=1. Operation resumes on the first rising edge after rst goes high.
- Simultaneous read and wq2 update are evaluated from the same pre-edge values; no priority logic is needed.

Test Plan:
- rst pulsed low mid-cycle -> rempty=1, raempty=1, rlevel=0, rgry=00000, rbin=0 immediately, without a clk edge.
- After reset, wgry=00001 held, read_enable=0 -> rempty stays 1 for 2 edges and is 0 after the 3rd edge; rlevel=1; raempty=1.
- From that state, read_enable=1 for one cycle -> next edge gives rbin=1, rgry=00001, rempty=1, rlevel=0. A further read_enable=1 leaves rbin=1 and rgry=00001.
- wgry stepped through the Gray code up to 16 entries (binary 10000, Gray 11000) -> rlevel=10000 and raempty=0. Reading 14 entries gives rlevel=2 and raempty=1.
- Full lap: 32 writes interleaved with 32 reads -> rgry returns to 00000, rbin wraps 15->0, rempty=1 at the end, and rlevel never exceeds 16.
- Reset asserted with rlevel=5 and read_enable=1 -> all outputs return to reset values; the first read after release is ignored until wgry is re-synchronised.
